alu_exec_unit: RTL and testbench

Execute-stage block of the single-cycle MIPS datapath. It decodes the 2-bit main-control ALU opcode and the 6-bit function field into a 4-bit ALU operation. It performs that operation on two 32-bit operands and registers the result and zero flag. It ANDs the registered zero flag with the registered Branch flag to produce the PC-source select for the branch mux.

---
 rtl/alu_exec_unit.sv | 83 ++++++++
 tb/tb_alu_exec_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// MIPS execute stage: ALU control decode, 32-bit ALU, registered result/zero
// and the branch select (branch_q & zero) for the PC-source mux.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic        branch,
    output logic [3:0]  alu_ctl,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        pc_src
);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_INV = 4'b1111;

    logic [3:0]  w_alu_ctl;
    logic [31:0] w_result;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_branch;

    always_comb begin
        w_alu_ctl = CTL_ADD;
        case (alu_op)
            2'b00: w_alu_ctl = CTL_ADD;
            2'b01: w_alu_ctl = CTL_SUB;
            2'b11: w_alu_ctl = CTL_ADD;
            2'b10: begin
                case (funct)
                    6'b100000: w_alu_ctl = CTL_ADD;
                    6'b100010: w_alu_ctl = CTL_SUB;
                    6'b100100: w_alu_ctl = CTL_AND;
                    6'b100101: w_alu_ctl = CTL_OR;
                    6'b100111: w_alu_ctl = CTL_NOR;
                    6'b101010: w_alu_ctl = CTL_SLT;
                    default:   w_alu_ctl = CTL_INV;
                endcase
            end
            default: w_alu_ctl = CTL_ADD;
        endcase
    end

    always_comb begin
        w_result = 32'h0;
        case (w_alu_ctl)
            CTL_AND: w_result = a & b;
            CTL_OR:  w_result = a | b;
            CTL_ADD: w_result = a + b;
            CTL_SUB: w_result = a - b;
            CTL_SLT: w_result = {31'b0, ($signed(a) < $signed(b))};
            CTL_NOR: w_result = ~(a | b);
            default: w_result = 32'h0;
        endcase
    end

    // Reset forces zero low rather than deriving it from the cleared result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 32'h0;
            r_zero   <= 1'b0;
            r_branch <= 1'b0;
        end else begin
            r_result <= w_result;
            r_zero   <= (w_result == 32'h0);
            r_branch <= branch;
        end
    end

    assign alu_ctl    = w_alu_ctl;
    assign alu_result = r_result;
    assign zero       = r_zero;
    assign pc_src     = r_branch & r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed plan vectors then random traffic,
// expected registered outputs queued at drive time and checked by a monitor.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        branch;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_result;
    logic        zero;
    logic        pc_src;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        pc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .alu_op(alu_op), .funct(funct),
        .branch(branch), .alu_ctl(alu_ctl), .alu_result(alu_result),
        .zero(zero), .pc_src(pc_src)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b01) return 4'b0110;
        if (op != 2'b10) return 4'b0010;
        case (f)
            6'd32:   return 4'b0010;
            6'd34:   return 4'b0110;
            6'd36:   return 4'b0000;
            6'd37:   return 4'b0001;
            6'd39:   return 4'b1100;
            6'd42:   return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // Result straight from the instruction meaning, not via the control code.
    function automatic logic [31:0] ref_res(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] op, input logic [5:0] f);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 2'b01) return 32'(x - y);
        if (op != 2'b10) return 32'(x + y);
        case (f)
            6'd32:   return 32'(x + y);
            6'd34:   return 32'(x - y);
            6'd36:   return x & y;
            6'd37:   return x | y;
            6'd39:   return ~(x | y);
            6'd42:   return (sx < sy) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input logic r, input logic [31:0] x, input logic [31:0] y,
                        input logic [1:0] op, input logic [5:0] f, input logic br,
                        input string name);
        exp_t e;
        @(negedge clk);
        rst = r; a = x; b = y; alu_op = op; funct = f; branch = br;
        #1;
        n_tests++;
        if (alu_ctl !== ref_ctl(op, f)) begin
            n_fail++;
            $display("FAIL %s alu_ctl got=%b want=%b", name, alu_ctl, ref_ctl(op, f));
        end
        if (r) begin
            e.res = 32'h0; e.z = 1'b0; e.pc = 1'b0;
        end else begin
            e.res = ref_res(x, y, op, f);
            e.z   = (e.res == 32'h0);
            e.pc  = br & e.z;
        end
        e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (alu_result !== e.res || zero !== e.z || pc_src !== e.pc) begin
                    n_fail++;
                    $display("FAIL %s got res=%h zero=%b pc_src=%b want res=%h zero=%b pc_src=%b",
                             e.name, alu_result, zero, pc_src, e.res, e.z, e.pc);
                end
            end
        end
    end

    initial begin : stim
        logic [5:0] f_list [7];
        logic [5:0] f;
        logic [1:0] op;
        logic [31:0] x, y;
        f_list = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0};
        rst = 1'b1; a = '0; b = '0; alu_op = '0; funct = '0; branch = 1'b0;

        step(1, 5, 5, 2'b01, 6'd0, 1, "reset");
        step(0, 5, 5, 2'b01, 6'd0, 1, "post_reset_beq");

        step(0, 32'hF0, 32'h0F, 2'b10, 6'd32, 0, "rtype_add");
        step(0, 32'hF0, 32'h0F, 2'b10, 6'd34, 0, "rtype_sub");
        step(0, 32'hF0, 32'h0F, 2'b10, 6'd36, 0, "rtype_and");
        step(0, 32'hF0, 32'h0F, 2'b10, 6'd37, 0, "rtype_or");
        step(0, 32'hF0, 32'h0F, 2'b10, 6'd39, 0, "rtype_nor");

        step(0, 32'hFFFF_FFFF, 1, 2'b10, 6'd42, 0, "slt_neg_lt_pos");
        step(0, 1, 32'hFFFF_FFFF, 2'b10, 6'd42, 0, "slt_pos_lt_neg");
        step(0, 7, 7, 2'b10, 6'd42, 0, "slt_equal");

        step(0, 32'h7FFF_FFFF, 1, 2'b10, 6'd32, 0, "add_ovf");
        step(0, 32'hFFFF_FFFF, 1, 2'b10, 6'd32, 0, "add_wrap");
        step(0, 0, 1, 2'b10, 6'd34, 0, "sub_wrap");

        step(0, 9, 9, 2'b01, 6'd0, 1, "beq_taken");
        step(0, 9, 8, 2'b01, 6'd0, 1, "beq_not_taken");
        step(0, 9, 9, 2'b01, 6'd0, 0, "beq_no_branch");

        step(0, 3, 4, 2'b10, 6'd0, 1, "invalid_funct");
        step(0, 100, 4, 2'b00, 6'd55, 0, "lw_add");
        step(0, 20, 22, 2'b11, 6'd34, 0, "op11_add");

        step(0, 1, 1, 2'b01, 6'd0, 1, "pre_mid_reset");
        step(1, 1, 1, 2'b01, 6'd0, 1, "mid_reset");
        step(0, 2, 3, 2'b00, 6'd0, 0, "resume");

        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : f_list[$urandom_range(0, 6)];
            x  = $urandom;
            y  = ($urandom_range(0, 4) == 0) ? x : $urandom;
            if ($urandom_range(0, 7) == 0) y = 32'($urandom_range(0, 3));
            step(($urandom_range(0, 29) == 0), x, y, op, f, 1'($urandom), "random");
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
